// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - multicycle sequencing controller for an external combinational multiplier
module mul_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               flush,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   mul_srcA,
  output logic [WIDTH-1:0]   mul_srcB,
  output logic               mul_ctrl,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  // A 4-bit counter covers the whole legal MUL_CYCLES range of 1..15.
  localparam int CW = 4;
  localparam logic [CW-1:0] COUNT_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] count;

  // Controller FSM: operand latch, hold window countdown, HI/LO writeback and direct writes.
  // Every output is a register so the multiplier inputs and the stall are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      mul_srcA <= '0;
      mul_srcB <= '0;
      mul_ctrl <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      // done is a pulse: cleared on every edge unless the writeback below sets it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Direct writes land at the same edge as an accepted start; the product
          // overwrites them later at writeback.
          if (hi_we) begin
            hi <= wdata;
          end
          if (lo_we) begin
            lo <= wdata;
          end
          // A start coinciding with flush belongs to a squashed instruction.
          if (start && !flush) begin
            mul_srcA <= op_a;
            mul_srcB <= op_b;
            mul_ctrl <= is_signed;
            count    <= COUNT_LOAD;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          // Operands stay frozen here; start, hi_we and lo_we are ignored.
          if (flush) begin
            // Flush wins even on the writeback edge: no HI/LO update, no done.
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            hi    <= mul_result[2*WIDTH-1:WIDTH];
            lo    <= mul_result[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          count <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard bench for mul_seq_ctrl with a behavioural HI/LO model
module tb_mul_seq_ctrl;

  localparam int W  = 32;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, is_signed, flush, hi_we, lo_we;
  logic [W-1:0]  op_a, op_b, wdata;
  logic [W-1:0]  mul_srcA, mul_srcB, hi, lo;
  logic          mul_ctrl, busy, done;
  logic [2*W-1:0] mul_result;

  logic          s1_start, s1_is_signed;
  logic [W-1:0]  s1_op_a, s1_op_b;
  logic [W-1:0]  s1_srcA, s1_srcB, s1_hi, s1_lo;
  logic          s1_ctrl, s1_busy, s1_done;
  logic [2*W-1:0] s1_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;
  exp_t exp_q[$];

  // Architectural model state.
  logic [W-1:0] m_hi, m_lo, last_a, last_b;
  logic         last_s;

  always #5 clk = ~clk;

  // Full-width product by plain arithmetic, signed or unsigned.
  function automatic logic [2*W-1:0] prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // The multiplier that sits outside the controller.
  assign mul_result = prod(mul_ctrl, mul_srcA, mul_srcB);
  assign s1_result  = prod(s1_ctrl, s1_srcA, s1_srcB);

  mul_seq_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .mul_srcA(mul_srcA), .mul_srcB(mul_srcB), .mul_ctrl(mul_ctrl),
    .mul_result(mul_result), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mul_seq_ctrl #(.WIDTH(W), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .is_signed(s1_is_signed),
    .op_a(s1_op_a), .op_b(s1_op_b), .flush(1'b0), .hi_we(1'b0), .lo_we(1'b0),
    .wdata('0), .mul_srcA(s1_srcA), .mul_srcB(s1_srcB), .mul_ctrl(s1_ctrl),
    .mul_result(s1_result), .busy(s1_busy), .done(s1_done), .hi(s1_hi), .lo(s1_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product_hi", {32'b0, hi}, {32'b0, e.hi});
        check("product_lo", {32'b0, lo}, {32'b0, e.lo});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Called 1 time unit after a rising edge with the DUT idle; returns the same way.
  // flush_at < 0: no flush; else flush during CALC cycle flush_at (MC-1 = writeback edge).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input int flush_at, input logic lo_co, input logic noise);
    logic [2*W-1:0] p;
    logic [W-1:0]   wd;
    bit             aborted;
    p = prod(sgn, a, b);
    wd = $urandom;
    aborted = 0;
    op_a = a; op_b = b; is_signed = sgn; start = 1'b1; lo_we = lo_co; wdata = wd;
    if (lo_co) m_lo = wd;
    last_a = a; last_b = b; last_s = sgn;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    for (int k = 0; k < MC; k++) begin
      if (noise) begin
        start = 1'b1; op_a = $urandom; op_b = $urandom; is_signed = $urandom;
        lo_we = 1'b1; hi_we = $urandom; wdata = $urandom;
      end
      if (k == flush_at) flush = 1'b1;
      if (k == MC - 1 && flush_at < 0) exp_q.push_back('{p[2*W-1:W], p[W-1:0]});
      @(negedge clk);
      check("busy_in_calc", {63'b0, busy}, 64'd1);
      check("srcA_hold", {32'b0, mul_srcA}, {32'b0, a});
      check("srcB_hold", {32'b0, mul_srcB}, {32'b0, b});
      check("ctrl_hold", {63'b0, mul_ctrl}, {63'b0, sgn});
      check("lo_in_calc", {32'b0, lo}, {32'b0, m_lo});
      check("hi_in_calc", {32'b0, hi}, {32'b0, m_hi});
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0; hi_we = 1'b0; flush = 1'b0;
      if (k == flush_at) begin
        aborted = 1;
        break;
      end
    end
    check("busy_after", {63'b0, busy}, 64'd0);
    if (aborted) begin
      check("done_after_flush", {63'b0, done}, 64'd0);
      check("hi_after_flush", {32'b0, hi}, {32'b0, m_hi});
      check("lo_after_flush", {32'b0, lo}, {32'b0, m_lo});
    end else begin
      check("done_pulse", {63'b0, done}, 64'd1);
      m_hi = p[2*W-1:W];
      m_lo = p[W-1:0];
    end
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [W-1:0] d);
    hi_we = hw; lo_we = lw; wdata = d;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("direct_hi", {32'b0, hi}, {32'b0, m_hi});
    check("direct_lo", {32'b0, lo}, {32'b0, m_lo});
  endtask

  // Idle cycles with wandering operands: the multiplier inputs must not move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      op_a = $urandom; op_b = $urandom; is_signed = $urandom;
      @(posedge clk); #1;
      check("idle_busy", {63'b0, busy}, 64'd0);
      check("idle_srcA", {32'b0, mul_srcA}, {32'b0, last_a});
      check("idle_srcB", {32'b0, mul_srcB}, {32'b0, last_b});
      check("idle_ctrl", {63'b0, mul_ctrl}, {63'b0, last_s});
    end
  endtask

  task automatic run1(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [2*W-1:0] p;
    p = prod(sgn, a, b);
    s1_op_a = a; s1_op_b = b; s1_is_signed = sgn; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    check("mc1_busy", {63'b0, s1_busy}, 64'd1);
    check("mc1_no_done", {63'b0, s1_done}, 64'd0);
    @(posedge clk); #1;
    check("mc1_busy_drop", {63'b0, s1_busy}, 64'd0);
    check("mc1_done", {63'b0, s1_done}, 64'd1);
    check("mc1_hi", {32'b0, s1_hi}, {32'b0, p[2*W-1:W]});
    check("mc1_lo", {32'b0, s1_lo}, {32'b0, p[W-1:0]});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; is_signed = 0; flush = 0; hi_we = 0; lo_we = 0;
    op_a = '0; op_b = '0; wdata = '0;
    s1_start = 0; s1_is_signed = 0; s1_op_a = '0; s1_op_b = '0;
    m_hi = '0; m_lo = '0; last_a = '0; last_b = '0; last_s = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_srcA", {32'b0, mul_srcA}, 64'd0);
    check("rst_srcB", {32'b0, mul_srcB}, 64'd0);
    check("rst_ctrl", {63'b0, mul_ctrl}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'hFFFFFFFD, 32'd5, 1'b1, -1, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'd2, 1'b0, -1, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'd2, 1'b1, -1, 1'b0, 1'b0);
    run_op(32'h80000000, 32'h80000000, 1'b1, -1, 1'b0, 1'b0);
    run_op(32'd7, 32'd6, 1'b0, -1, 1'b0, 1'b0);
    check("b2b_lo_const", {32'b0, lo}, 64'h2A);
    check("b2b_hi_const", {32'b0, hi}, 64'h0);
    write_hilo(1'b1, 1'b0, 32'h12345678);
    run_op(32'd3, 32'd3, 1'b0, 1, 1'b0, 1'b0);
    run_op(32'd3, 32'd3, 1'b0, MC - 1, 1'b0, 1'b0);
    check("flush_hi_const", {32'b0, hi}, 64'h12345678);
    run_op($urandom, $urandom, 1'b1, -1, 1'b0, 1'b1);
    run_op($urandom, $urandom, 1'b0, -1, 1'b1, 1'b0);
    idle(3);

    // Start squashed by a coincident flush in IDLE.
    op_a = $urandom; op_b = $urandom; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {63'b0, busy}, 64'd0);
    check("start_flush_srcA", {32'b0, mul_srcA}, {32'b0, last_a});
    write_hilo(1'b1, 1'b1, $urandom);

    for (int i = 0; i < 40; i++) begin
      int fa;
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MC - 1)) : -1;
      run_op($urandom, $urandom, 1'($urandom), fa, 1'($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 5) == 0) write_hilo(1'($urandom), 1'($urandom), $urandom);
    end

    // Asynchronous reset in the middle of a multiply.
    op_a = $urandom; op_b = $urandom; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_hi", {32'b0, hi}, 64'd0);
    check("arst_lo", {32'b0, lo}, 64'd0);
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_done", {63'b0, done}, 64'd0);
    check("arst_srcA", {32'b0, mul_srcA}, 64'd0);
    check("arst_srcB", {32'b0, mul_srcB}, 64'd0);
    check("arst_ctrl", {63'b0, mul_ctrl}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0; last_a = '0; last_b = '0; last_s = 0;
    idle(4);

    run1(32'hFFFFFFFD, 32'd5, 1'b1);
    for (int i = 0; i < 6; i++) run1($urandom, $urandom, 1'($urandom));

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
